// File: rtl/keypad_scanner.sv
// 4x4 active-low matrix keypad scanner with frame-level debounce.
// Emits one qualified key code per physical press; multi-key frames are flagged and ignored.
module keypad_scanner #(
  parameter int SCAN_DIV        = 50_000,
  parameter int DEBOUNCE_FRAMES = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_err
);

  localparam int             DW      = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]  DIV_MAX = DW'(SCAN_DIV - 1);
  localparam logic [7:0]     DB_MAX  = 8'(DEBOUNCE_FRAMES);

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD, RELEASE} state_t;

  logic [DW-1:0] div_cnt;
  logic [1:0]    col_idx;
  logic [3:0]    row_s1, row_s2;
  logic [11:0]   frame;
  state_t        state;
  logic [3:0]    cand;
  logic [7:0]    stab, rel;

  logic          scan_tick, frame_done;
  logic [15:0]   full_frame;
  logic [4:0]    pop;
  logic [3:0]    code;
  logic          none, single, multi;

  assign scan_tick  = (div_cnt == DIV_MAX);
  assign frame_done = scan_tick && (col_idx == 2'd3);

  // Column 3 is classified straight from the synchronizer so the FSM acts on the completing tick.
  assign full_frame = {~row_s2, frame};

  always_comb begin
    pop  = '0;
    code = '0;
    for (int i = 0; i < 16; i++) begin
      if (full_frame[i]) begin
        pop  = pop + 5'd1;
        code = {i[1:0], i[3:2]};
      end
    end
  end

  assign none   = (pop == 5'd0);
  assign single = (pop == 5'd1);
  assign multi  = (pop > 5'd1);

  // Columns are scanned in order, so a shift register yields frame[col*4+row] for cols 0..2.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt <= '0;
      col_idx <= 2'd0;
      col_out <= 4'b1110;
      row_s1  <= 4'b1111;
      row_s2  <= 4'b1111;
      frame   <= '0;
    end else begin
      row_s1 <= row_in;
      row_s2 <= row_s1;
      if (scan_tick) begin
        div_cnt <= '0;
        col_idx <= col_idx + 2'd1;
        col_out <= ~(4'b0001 << (col_idx + 2'd1));
        frame   <= {~row_s2, frame[11:4]};
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cand      <= '0;
      stab      <= '0;
      rel       <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      key_held  <= 1'b0;
      multi_err <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      multi_err <= frame_done && multi;
      if (frame_done) begin
        case (state)
          IDLE: begin
            if (single) begin
              if (DEBOUNCE_FRAMES == 1) begin
                key_code  <= code;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                state     <= HELD;
              end else begin
                cand  <= code;
                stab  <= 8'd1;
                state <= DEBOUNCE;
              end
            end
          end
          DEBOUNCE: begin
            if (single && code == cand) begin
              if (stab + 8'd1 == DB_MAX) begin
                key_code  <= cand;
                key_valid <= 1'b1;
                key_held  <= 1'b1;
                state     <= HELD;
              end else begin
                stab <= stab + 8'd1;
              end
            end else if (single) begin
              cand <= code;
              stab <= 8'd1;
            end else begin
              state <= IDLE;
            end
          end
          HELD: begin
            if (none) begin
              if (DEBOUNCE_FRAMES == 1) begin
                key_held <= 1'b0;
                state    <= IDLE;
              end else begin
                rel   <= 8'd1;
                state <= RELEASE;
              end
            end
          end
          RELEASE: begin
            if (none) begin
              if (rel + 8'd1 == DB_MAX) begin
                key_held <= 1'b0;
                state    <= IDLE;
              end else begin
                rel <= rel + 8'd1;
              end
            end else begin
              rel   <= '0;
              state <= HELD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
